// File: rtl/tmds_decoder_if.sv
// Symbol and decode-result bundle for one TMDS channel decoder.
interface tmds_decoder_if;
   logic [9:0]  sym_in;
   logic        sym_valid;
   logic [7:0]  data;
   logic [1:0]  ctrl;
   logic        de;
   logic        out_valid;
   logic        locked;
   logic        bitslip;
   logic [15:0] err_cnt;

   modport master (
      output sym_in,
      output sym_valid,
      input  data,
      input  ctrl,
      input  de,
      input  out_valid,
      input  locked,
      input  bitslip,
      input  err_cnt
   );

   modport slave (
      input  sym_in,
      input  sym_valid,
      output data,
      output ctrl,
      output de,
      output out_valid,
      output locked,
      output bitslip,
      output err_cnt
   );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS 10b/8b channel decoder with word-alignment FSM.
// Define TMDS_ERR_CNT_EN to count bitslips and lock losses on err_cnt.
module tmds_decoder #(
   parameter int CTRL_MIN   = 12,
   parameter int SEARCH_WIN = 2048,
   parameter int SLIP_WAIT  = 16,
   parameter int LOSS_WIN   = 4096
) (
   input  logic          clk,
   input  logic          rst,
   tmds_decoder_if.slave bus
);
   localparam int RW = $clog2(CTRL_MIN + 1);
   localparam int WW = $clog2(SEARCH_WIN + 1);
   localparam int LW = $clog2(LOSS_WIN + 1);
   localparam int SW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

   localparam logic [RW-1:0] RUN_MAX   = RW'(CTRL_MIN);
   localparam logic [RW-1:0] RUN_LAST  = RW'(CTRL_MIN - 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(SEARCH_WIN - 1);
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_WIN - 1);
   localparam logic [SW-1:0] SLIP_LAST = SW'(SLIP_WAIT - 1);

   localparam logic [9:0] TOK_00 = 10'b1101010100;
   localparam logic [9:0] TOK_01 = 10'b0010101011;
   localparam logic [9:0] TOK_10 = 10'b0101010100;
   localparam logic [9:0] TOK_11 = 10'b1010101011;

   typedef enum logic [1:0] {
      S_SEARCH,
      S_SLIP,
      S_LOCKED
   } state_e;

   state_e        state_q, state_d;
   logic [9:0]    sym1_q;
   logic          vld1_q;
   logic          ovld_q;
   logic [7:0]    data_q, data_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic          de_q, de_d;
   logic          locked_q, locked_d;
   logic          bitslip_q, bitslip_d;
   logic [RW-1:0] run_q, run_d;
   logic [WW-1:0] win_q, win_d;
   logic [LW-1:0] loss_q, loss_d;
   logic [SW-1:0] slip_q, slip_d;

   logic          is_tok;
   logic [1:0]    tok;
   logic [7:0]    q;
   logic [7:0]    dec;
   logic          acc;
   logic          done;
   logic [RW-1:0] run_inc;

   always_comb begin
      is_tok = 1'b1;
      tok    = 2'b00;
      unique case (sym1_q)
         TOK_00:  tok = 2'b00;
         TOK_01:  tok = 2'b01;
         TOK_10:  tok = 2'b10;
         TOK_11:  tok = 2'b11;
         default: is_tok = 1'b0;
      endcase
   end

   always_comb begin
      q      = sym1_q[9] ? ~sym1_q[7:0] : sym1_q[7:0];
      dec    = '0;
      dec[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         dec[i] = sym1_q[8] ? (q[i] ^ q[i-1])
                            : ~(q[i] ^ q[i-1]);
      end
   end

   // Symbols reaching stage 2 during SLIP are dropped by the FSM.
   assign acc     = vld1_q && (state_q != S_SLIP);
   assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
   assign done    = acc && is_tok && (run_q == RUN_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      win_d     = win_q;
      loss_d    = loss_q;
      slip_d    = slip_q;
      bitslip_d = 1'b0;
      unique case (state_q)
         S_SEARCH: begin
            if (acc) begin
               run_d = is_tok ? run_inc : '0;
               win_d = win_q + 1'b1;
               if (done) begin
                  state_d = S_LOCKED;
                  win_d   = '0;
                  loss_d  = '0;
               end else if (win_q == WIN_LAST) begin
                  state_d   = S_SLIP;
                  bitslip_d = 1'b1;
                  run_d     = '0;
                  win_d     = '0;
                  slip_d    = '0;
               end
            end
         end
         S_SLIP: begin
            run_d  = '0;
            win_d  = '0;
            slip_d = slip_q + 1'b1;
            if (slip_q == SLIP_LAST) begin
               state_d = S_SEARCH;
               slip_d  = '0;
            end
         end
         S_LOCKED: begin
            if (acc) begin
               run_d  = is_tok ? run_inc : '0;
               loss_d = loss_q + 1'b1;
               if (done) begin
                  loss_d = '0;
               end else if (loss_q == LOSS_LAST) begin
                  state_d = S_SEARCH;
                  run_d   = '0;
                  win_d   = '0;
                  loss_d  = '0;
               end
            end
         end
         default: state_d = S_SEARCH;
      endcase
   end

   assign locked_d = (state_d == S_LOCKED);

   // Pixel data is blanked whenever the post-edge lock state is low.
   always_comb begin
      data_d = data_q;
      ctrl_d = ctrl_q;
      de_d   = de_q;
      if (vld1_q) begin
         if (is_tok) begin
            ctrl_d = tok;
            data_d = '0;
            de_d   = 1'b0;
         end else begin
            data_d = locked_d ? dec : '0;
            de_d   = locked_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sym1_q    <= '0;
         vld1_q    <= 1'b0;
         ovld_q    <= 1'b0;
         data_q    <= '0;
         ctrl_q    <= '0;
         de_q      <= 1'b0;
         locked_q  <= 1'b0;
         bitslip_q <= 1'b0;
         run_q     <= '0;
         win_q     <= '0;
         loss_q    <= '0;
         slip_q    <= '0;
      end else begin
         if (bus.sym_valid) begin
            sym1_q <= bus.sym_in;
         end
         vld1_q    <= bus.sym_valid;
         ovld_q    <= vld1_q;
         data_q    <= data_d;
         ctrl_q    <= ctrl_d;
         de_q      <= de_d;
         locked_q  <= locked_d;
         bitslip_q <= bitslip_d;
         run_q     <= run_d;
         win_q     <= win_d;
         loss_q    <= loss_d;
         slip_q    <= slip_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.ctrl      = ctrl_q;
   assign bus.de        = de_q;
   assign bus.out_valid = ovld_q;
   assign bus.locked    = locked_q;
   assign bus.bitslip   = bitslip_q;

`ifdef TMDS_ERR_CNT_EN
   logic [15:0] err_q, err_d;
   logic        loss_ev;

   assign loss_ev = (state_q == S_LOCKED) && (state_d == S_SEARCH);

   always_comb begin
      err_d = err_q;
      if ((bitslip_d || loss_ev) && (err_q != 16'hFFFF)) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.err_cnt = err_q;
`else
   assign bus.err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: directed tables, corner sequences, random vs model.
module tb_tmds_decoder;
   localparam int CTRL_MIN   = 12;
   localparam int SEARCH_WIN = 2048;
   localparam int SLIP_WAIT  = 16;
   localparam int LOSS_WIN   = 4096;

`ifdef TMDS_ERR_CNT_EN
   localparam int EXP_ERR1 = 1;
`else
   localparam int EXP_ERR1 = 0;
`endif

   localparam logic [9:0] TOKS [4] = '{
      10'b1101010100, 10'b0010101011,
      10'b0101010100, 10'b1010101011
   };

   localparam int M_SEARCH = 0;
   localparam int M_SLIP   = 1;
   localparam int M_LOCKED = 2;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;
   bit   started  = 1'b0;

   tmds_decoder_if bus ();

   tmds_decoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic int tok_idx(input logic [9:0] s);
      for (int i = 0; i < 4; i++) begin
         if (s == TOKS[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [7:0] ref_dec(input logic [9:0] s);
      logic [7:0] qq, d;
      qq = s[9] ? ~s[7:0] : s[7:0];
      d  = qq ^ {qq[6:0], 1'b0};
      if (!s[8]) d = d ^ 8'hFE;
      return d;
   endfunction

   function automatic logic [9:0] rand_data();
      logic [9:0] s;
      do s = 10'($urandom); while (tok_idx(s) >= 0);
      return s;
   endfunction

   // Reference model: one symbol delay, then the lock/decode rules.
   typedef struct packed {
      logic [9:0] sym;
      logic       v;
   } hs_t;

   hs_t        hist [$];
   int         m_mode, m_run, m_win, m_loss, m_slip, m_err;
   logic [7:0] m_data;
   logic [1:0] m_ctrl;
   logic       m_de, m_ovld, m_bitslip;

   task automatic model_step(input logic r, input logic [9:0] s,
                             input logic v);
      hs_t  e, n;
      int   t;
      logic ign, done;
      if (r) begin
         hist.delete();
         m_mode = M_SEARCH;
         m_run = 0; m_win = 0; m_loss = 0; m_slip = 0; m_err = 0;
         m_data = '0; m_ctrl = '0; m_de = 0; m_ovld = 0; m_bitslip = 0;
         return;
      end
      e = '0;
      if (hist.size() > 0) e = hist.pop_front();
      n.sym = s;
      n.v   = v;
      hist.push_back(n);
      m_bitslip = 1'b0;
      m_ovld    = e.v;
      ign = (m_mode == M_SLIP);
      if (ign) begin
         m_slip--;
         m_run = 0;
         m_win = 0;
         if (m_slip == 0) m_mode = M_SEARCH;
      end
      if (!e.v) return;
      t = tok_idx(e.sym);
      if (!ign) begin
         if (t >= 0) m_run++;
         else m_run = 0;
         done = (m_run == CTRL_MIN);
         if (m_mode == M_SEARCH) begin
            m_win++;
            if (done) begin
               m_mode = M_LOCKED;
               m_win = 0;
               m_loss = 0;
            end else if (m_win == SEARCH_WIN) begin
               m_mode = M_SLIP;
               m_bitslip = 1'b1;
               m_slip = SLIP_WAIT;
               m_run = 0;
               m_win = 0;
               if (m_err < 65535) m_err++;
            end
         end else begin
            m_loss++;
            if (done) begin
               m_loss = 0;
            end else if (m_loss == LOSS_WIN) begin
               m_mode = M_SEARCH;
               m_run = 0; m_win = 0; m_loss = 0;
               if (m_err < 65535) m_err++;
            end
         end
      end
      if (t >= 0) begin
         m_ctrl = 2'(t);
         m_data = '0;
         m_de   = 1'b0;
      end else if (m_mode == M_LOCKED) begin
         m_data = ref_dec(e.sym);
         m_de   = 1'b1;
      end else begin
         m_data = '0;
         m_de   = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      model_step(rst, bus.sym_in, bus.sym_valid);
      started = 1'b1;
   end

   always @(negedge clk) begin
      if (started) begin
         int   exp_err;
         logic ml;
         exp_err = (EXP_ERR1 != 0) ? m_err : 0;
         ml = (m_mode == M_LOCKED);
         n_assert++;
         if (bus.data !== m_data || bus.ctrl !== m_ctrl ||
             bus.de !== m_de || bus.out_valid !== m_ovld ||
             bus.locked !== ml || bus.bitslip !== m_bitslip ||
             int'(bus.err_cnt) != exp_err) begin
            n_fail++;
            $display("FAIL model t=%0t got d=%h c=%0d de=%b ov=%b lk=%b bs=%b e=%0d want d=%h c=%0d de=%b ov=%b lk=%b bs=%b e=%0d",
               $time, bus.data, bus.ctrl, bus.de, bus.out_valid,
               bus.locked, bus.bitslip, bus.err_cnt, m_data, m_ctrl,
               m_de, m_ovld, ml, m_bitslip, exp_err);
         end
      end
   end

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input logic [9:0] s, input logic v);
      bus.sym_in    = s;
      bus.sym_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick('0, 1'b0);
      tick('0, 1'b0);
      rst = 1'b0;
   endtask

   function automatic longint outs();
      return {bus.data, bus.ctrl, bus.de, bus.out_valid,
              bus.locked, bus.bitslip, bus.err_cnt};
   endfunction

   typedef struct {
      logic [9:0] sym;
      logic [7:0] data;
      logic       de;
      logic [1:0] ctrl;
   } vec_t;

   vec_t vecs [11];

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{10'b1101010100, 8'h00, 1'b0, 2'b00};
      vecs[1]  = '{10'b0100000000, 8'h00, 1'b1, 2'b00};
      vecs[2]  = '{10'b1011111111, 8'hFE, 1'b1, 2'b00};
      vecs[3]  = '{10'b0010101011, 8'h00, 1'b0, 2'b01};
      vecs[4]  = '{10'b0111111111, 8'h01, 1'b1, 2'b01};
      vecs[5]  = '{10'b0101010100, 8'h00, 1'b0, 2'b10};
      vecs[6]  = '{10'b1000000000, 8'hFF, 1'b1, 2'b10};
      vecs[7]  = '{10'b1010101011, 8'h00, 1'b0, 2'b11};
      vecs[8]  = '{10'b0100000001, 8'h03, 1'b1, 2'b11};
      vecs[9]  = '{10'b0001010101, 8'h01, 1'b1, 2'b11};
      vecs[10] = '{10'b0000000000, 8'hFE, 1'b1, 2'b11};

      rst = 1'b1;
      bus.sym_in = '0;
      bus.sym_valid = 1'b0;

      // Reset with random inputs
      for (int k = 0; k < 3; k++) begin
         tick(10'($urandom), 1'($urandom));
         chk("reset_outs", outs(), 0);
      end
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick(rand_data(), 1'b1);
         chk("post_reset_unlocked", bus.locked, 0);
      end

      // Lock acquire
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         tick(TOKS[0], 1'b1);
         chk("acq_locked", bus.locked, (k >= 13) ? 1 : 0);
         chk("acq_bitslip", bus.bitslip, 0);
         chk("acq_de_ctrl", {bus.de, bus.ctrl}, 0);
      end

      // Decode table while locked
      for (int i = 0; i < 11; i++) begin
         tick(vecs[i].sym, 1'b1);
         if (i > 0) begin
            chk("tbl_data", bus.data, vecs[i-1].data);
            chk("tbl_de", bus.de, vecs[i-1].de);
            chk("tbl_ctrl", bus.ctrl, vecs[i-1].ctrl);
            chk("tbl_ovld", bus.out_valid, 1);
         end
      end
      tick('0, 1'b0);
      chk("tbl_data_last", bus.data, vecs[10].data);
      chk("tbl_de_last", bus.de, vecs[10].de);

      // 11 tokens, data, 11 tokens: no lock
      do_reset();
      for (int k = 0; k < 23; k++) begin
         tick((k == 11) ? rand_data() : TOKS[k % 4], 1'b1);
         chk("short_run_unlocked", bus.locked, 0);
      end
      tick('0, 1'b0);
      tick('0, 1'b0);
      chk("short_run_final", bus.locked, 0);

      // Gapped sym_valid during a 12-token run
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         tick(TOKS[k % 4], 1'b1);
         chk("gap_locked_v", bus.locked, 0);
         tick(rand_data(), 1'b0);
         chk("gap_locked_i", bus.locked, (k == 12) ? 1 : 0);
      end

      // Search failure, slip, ignored symbols, relock
      do_reset();
      for (int k = 0; k < SEARCH_WIN; k++) tick(rand_data(), 1'b1);
      chk("srch_no_slip_yet", bus.bitslip, 0);
      for (int j = 1; j <= SLIP_WAIT; j++) begin
         tick(TOKS[1], 1'b1);
         if (j == 1) begin
            chk("srch_bitslip", bus.bitslip, 1);
            chk("srch_err", bus.err_cnt, EXP_ERR1);
         end
         if (j == 2) chk("srch_bitslip_1cyc", bus.bitslip, 0);
      end
      for (int j = 0; j < CTRL_MIN - 1; j++) tick(TOKS[2], 1'b1);
      chk("slip_ignored", bus.locked, 0);
      tick(TOKS[2], 1'b1);
      chk("relock_pre", bus.locked, 0);
      tick('0, 1'b0);
      chk("relock", bus.locked, 1);
      chk("relock_err", bus.err_cnt, EXP_ERR1);

      // Loss of lock
      do_reset();
      for (int k = 0; k < CTRL_MIN; k++) tick(TOKS[3], 1'b1);
      for (int k = 0; k < LOSS_WIN; k++) tick(10'b0100000001, 1'b1);
      chk("loss_pre_locked", bus.locked, 1);
      chk("loss_pre_data", {bus.data, bus.de}, {8'h03, 1'b1});
      tick('0, 1'b0);
      chk("loss_locked", bus.locked, 0);
      chk("loss_data_de", {bus.data, bus.de}, 0);
      chk("loss_bitslip", bus.bitslip, 0);
      chk("loss_err", bus.err_cnt, EXP_ERR1);

      // Reset cancels a pending bitslip
      do_reset();
      for (int k = 0; k < SEARCH_WIN; k++) tick(rand_data(), 1'b1);
      rst = 1'b1;
      tick(TOKS[0], 1'b1);
      chk("rst_cancel", outs(), 0);
      rst = 1'b0;
      tick('0, 1'b0);
      chk("rst_cancel_after", {bus.bitslip, bus.err_cnt}, 0);

      // Random segments against the model
      do_reset();
      begin
         int cyc;
         cyc = 0;
         while (cyc < 8000) begin
            bit ts;
            int len;
            ts  = ($urandom_range(0, 1) == 1);
            len = ts ? $urandom_range(6, 18) : $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
               logic [9:0] s;
               s = ts ? TOKS[$urandom_range(0, 3)] : rand_data();
               rst = ($urandom_range(0, 199) == 0);
               tick(s, ($urandom_range(0, 3) != 0));
               cyc++;
            end
         end
      end
      rst = 1'b0;
      tick('0, 1'b0);
      tick('0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
